shift_normalizer: RTL and testbench
===================================

# shift_normalizer

Multi-cycle normalizer that inverts the ALU shifter's job: given an operand, it finds the left-shift amount that normalizes it and returns both the normalized value and that amount. It uses a start/busy/done handshake and shifts one bit position per cycle. It sits beside the ALU and feeds count-leading-zeros / count-leading-sign style results back to the pipeline. The shift-amount output uses the same 6-bit width as the shifter's `shamt`, so the result can drive that shifter directly.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a normalization; sampled only when `busy`=0.
- `a` input 32: operand, captured on the edge where `start` is accepted.
- `mode` input 1: captured with `a`.
  - 0 = unsigned: normalize until bit 31 = 1.
  - 1 = signed: normalize until bit 31 != bit 30.
- `busy` output 1: high while a normalization is in progress; `start` is ignored while high.
- `done` output 1: one-cycle pulse marking that `r`/`shamt`/`zero` are valid.
- `r` output 32: normalized value, i.e. `a << shamt`.
- `shamt` output 6: number of left shifts applied (0..32).
- `zero` output 1: high when the operand had no normalizing bit (see special cases).

## Operation
- States: IDLE, SHIFT, DONE.
- Registered working value `w[31:0]` and counter `cnt[5:0]`; `r`=`w` and `shamt`=`cnt`, both registered.
- Start acceptance: in IDLE or DONE, `start`=1 at an edge:
  - load `w`=`a`, `cnt`=0, latch `mode`;
  - go to SHIFT, except for the special cases below.
- Special cases, decided at load time (go straight to DONE, `cnt` set directly):
  - `mode`=0, `a`=0: `shamt`=32, `r`=0, `zero`=1.
  - `mode`=1, `a`=0x00000000 or 0xFFFFFFFF: `shamt`=31, `r`=`a`<<31 (0x00000000 / 0x80000000), `zero`=1.
  - In all other cases `zero`=0.
- SHIFT, at each edge:
  - if `w` is normalized for the latched mode, go to DONE, `w`/`cnt` unchanged;
  - else `w`=`w`<<1 (zero fill) and `cnt`=`cnt`+1.
  - `cnt` never exceeds 31 in SHIFT; operands that would exceed it are caught by the special cases.
- DONE lasts one cycle:
  - `done`=1;
  - next edge goes to IDLE, or reloads if `start`=1 (back-to-back operation).
- `busy`=1 exactly in SHIFT.
- `start` during SHIFT is ignored; no queuing.
- `r`, `shamt` and `zero` hold their last result until the next accepted `start` overwrites them at load.
- Already-normalized input (e.g. `mode`=0, `a`=0x80000000) takes the SHIFT path with zero shifts.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `r`=0, `shamt`=0, `zero`=0.
- `rst` overrides everything, including mid-SHIFT and a simultaneous `start`; the operation is abandoned and no `done` is issued.
- Accepted start at edge N, general case with final `shamt`=k:
  - edges N+1..N+k perform the shifts;
  - edge N+k+1 enters DONE;
  - `done` is high in the cycle following edge N+k+1.
- Latency from accepting edge to `done` visible: k+1 cycles after the first cycle; range 1..32 (k=0..31).
- Special cases: DONE entered at edge N; `done` high the cycle immediately after the start edge.
- `busy` rises the cycle after edge N (non-special) and falls the same cycle `done` rises.
- Back-to-back: `start` sampled high in the DONE cycle loads at that edge; `done` is not repeated for the old result.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles with `start`=1 -> `busy`=0, `done`=0, `r`=0, `shamt`=0, `zero`=0 throughout.
- Unsigned sweep: `mode`=0.
  - `a`=0x00000001 -> `r`=0x80000000, `shamt`=31, `done` 32 cycles after start.
  - `a`=0x80000000 -> `shamt`=0, `done` 1 cycle after.
  - `a`=0x00F00000 -> `r`=0xF0000000, `shamt`=8.
- Zero/sign specials:
  - `mode`=0, `a`=0 -> `shamt`=32, `zero`=1, `done` next cycle.
  - `mode`=1, `a`=0xFFFFFFFF -> `r`=0x80000000, `shamt`=31, `zero`=1.
- Signed normal: `mode`=1.
  - `a`=0xFFFFF000 -> `r`=0x80000000, `shamt`=19.
  - `a`=0x00000003 -> `r`=0x60000000, `shamt`=29.
- Handshake:
  - `start` pulsed mid-SHIFT with a different `a` -> ignored, original result returned.
  - `start` held in the DONE cycle -> new operation loaded, single `done` per operation.
- Reset mid-op: `rst` asserted 5 cycles into `a`=0x00000001 -> IDLE next cycle, outputs 0, no `done` pulse.

Source files
------------

// File: rtl/shift_normalizer_if.sv
// rtl/shift_normalizer_if.sv - start/busy/done handshake and result bus of the normalizer
interface shift_normalizer_if;
    logic        start;
    logic [31:0] a;
    logic        mode;
    logic        busy;
    logic        done;
    logic [31:0] r;
    logic [5:0]  shamt;
    logic        zero;

    modport master (
        output start, a, mode,
        input  busy, done, r, shamt, zero
    );

    modport slave (
        input  start, a, mode,
        output busy, done, r, shamt, zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - one-bit-per-cycle left normalizer returning value and shift amount
module shift_normalizer (
    input  logic              clk,
    input  logic              rst,
    shift_normalizer_if.slave nif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        zero_q, zero_d;
    logic        normalized;

    // Unsigned stops on a leading one; signed stops where the sign bit and the next bit differ.
    assign normalized = mode_q ? (w_q[31] ^ w_q[30]) : w_q[31];

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= 32'd0;
            cnt_q   <= 6'd0;
            mode_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state: load on start (IDLE/DONE), resolve all-zero / all-sign operands at load, shift otherwise.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (nif.start) begin
                    w_d     = nif.a;
                    cnt_d   = 6'd0;
                    mode_d  = nif.mode;
                    zero_d  = 1'b0;
                    state_d = ST_SHIFT;
                    if (!nif.mode && (nif.a == 32'd0)) begin
                        cnt_d   = 6'd32;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (nif.mode && ((nif.a == 32'd0) || (nif.a == 32'hFFFF_FFFF))) begin
                        w_d     = nif.a << 31;
                        cnt_d   = 6'd31;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (normalized) begin
                    state_d = ST_DONE;
                end else begin
                    w_d   = {w_q[30:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign nif.busy  = (state_q == ST_SHIFT);
    assign nif.done  = (state_q == ST_DONE);
    assign nif.r     = w_q;
    assign nif.shamt = cnt_q;
    assign nif.zero  = zero_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - scoreboard testbench for shift_normalizer
module tb_shift_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    typedef struct {
        logic [31:0] r;
        logic [5:0]  sh;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    shift_normalizer_if nif ();

    shift_normalizer dut (
        .clk (clk),
        .rst (rst),
        .nif (nif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: shift amount is the length of the run of redundant leading bits.
    function automatic exp_t model(input logic [31:0] x, input logic m);
        exp_t e;
        int k;
        e.z = 1'b0;
        k = 0;
        if (!m) begin
            if (x == 32'd0) begin
                k = 32;
                e.z = 1'b1;
            end else begin
                while (x[31-k] == 1'b0) k++;
            end
        end else begin
            if (x == 32'd0 || x == 32'hFFFF_FFFF) begin
                k = 31;
                e.z = 1'b1;
            end else begin
                while (x[30-k] == x[31]) k++;
            end
        end
        e.sh  = 6'(k);
        e.r   = (k >= 32) ? 32'd0 : (x << k);
        e.lat = e.z ? 0 : k + 1;
        e.acc = 0;
        return e;
    endfunction

    // Caller is at a negedge with the DUT in IDLE or DONE, so this start is accepted.
    task automatic issue(input logic [31:0] x, input logic m);
        exp_t e;
        nif.start = 1'b1;
        nif.a     = x;
        nif.mode  = m;
        @(posedge clk);
        #1;
        e = model(x, m);
        e.acc = cyc;
        exp_q.push_back(e);
        nif.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nif.done) return;
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},  64'(nif.busy),  64'd0);
        chk({tag, "_done"},  64'(nif.done),  64'd0);
        chk({tag, "_r"},     64'(nif.r),     64'd0);
        chk({tag, "_shamt"}, 64'(nif.shamt), 64'd0);
        chk({tag, "_zero"},  64'(nif.zero),  64'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && nif.done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("r",       64'(nif.r),     64'(e.r));
                chk("shamt",   64'(nif.shamt), 64'(e.sh));
                chk("zero",    64'(nif.zero),  64'(e.z));
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                chk("busy_at_done", 64'(nif.busy), 64'd0);
            end
        end
    end

    logic [31:0] dir_a [8] = '{32'h0000_0001, 32'h8000_0000, 32'h00F0_0000, 32'h0000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0000_0003, 32'h0000_0000};
    logic        dir_m [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        nif.start = 1'b1;
        nif.a     = 32'h1234_5678;
        nif.mode  = 1'b0;
        rst       = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_cleared("reset");
        end
        rst = 1'b0;
        nif.start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(dir_a[i], dir_m[i]);
            wait_done();
            @(negedge clk);
        end

        // start pulsed during SHIFT must not disturb the running operation
        issue(32'h0001_0000, 1'b0);
        repeat (3) @(negedge clk);
        nif.start = 1'b1;
        nif.a     = 32'h0000_0001;
        nif.mode  = 1'b1;
        @(negedge clk);
        nif.start = 1'b0;
        wait_done();
        @(negedge clk);

        // start held in the DONE cycle reloads back-to-back
        issue(32'h0000_0100, 1'b0);
        wait_done();
        issue(32'h0000_0004, 1'b1);
        wait_done();
        issue(32'h0000_0000, 1'b0);
        wait_done();
        @(negedge clk);

        // reset mid-operation abandons it without a done pulse
        issue(32'h0000_0001, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_cleared("rst_midop");
        rst = 1'b0;
        repeat (40) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] x;
            logic        m;
            m = 1'($urandom_range(0, 1));
            x = $urandom;
            x = x >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) x = 32'd0;
            if (m && $urandom_range(0, 1) == 1) x = ~x;
            issue(x, m);
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
